// File: rtl/usrt_pkg.sv
// usrt_pkg: shared parity codes, frame bit positions and receive FSM states
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int START_BIT = 10;
    localparam int DATA_MSB  = 9;
    localparam int DATA_LSB  = 2;
    localparam int PAR_BIT   = 1;
    localparam int STOP_BIT  = 0;

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    // 00 and 11 both mean "no parity bit on the line"
    function automatic logic par_none(input logic [1:0] m);
        return m[0] == m[1];
    endfunction

endpackage

// File: rtl/usrt_rx_ctrl_if.sv
// usrt_rx_ctrl_if: checker handoff and output byte stream of the receive sequencer
interface usrt_rx_ctrl_if;

    logic [10:0] o_Frame;
    logic        o_FrameStb;
    logic [1:0]  o_ChkParity;
    logic        i_ParityOK;
    logic [7:0]  o_Data;
    logic        o_Valid;
    logic        i_Ready;

    modport master (
        output o_Frame, o_FrameStb, o_ChkParity, o_Data, o_Valid,
        input  i_ParityOK, i_Ready
    );

    modport slave (
        input  o_Frame, o_FrameStb, o_ChkParity, o_Data, o_Valid,
        output i_ParityOK, i_Ready
    );

endinterface

// File: rtl/usrt_rx_fifo.sv
// usrt_rx_fifo: small synchronous byte FIFO; a push while full only lands if a pop frees a slot
module usrt_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       i_Pclk,
    input  logic       i_Rst,
    input  logic       i_Push,
    input  logic       i_Pop,
    input  logic [7:0] i_Din,
    output logic [7:0] o_Dout,
    output logic       o_Full,
    output logic       o_Empty
);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;

    assign o_Full  = cnt == (AW+1)'(DEPTH);
    assign o_Empty = cnt == '0;
    assign rd      = i_Pop & ~o_Empty;
    assign wr      = i_Push & (~o_Full | rd);
    assign o_Dout  = o_Empty ? 8'd0 : mem[rp];

    // storage write, no reset needed since the head is masked while empty
    always_ff @(posedge i_Pclk) begin
        if (wr) mem[wp] <= i_Din;
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/usrt_rx_ctrl.sv
// usrt_rx_ctrl: samples the serial line, hands frames to the parity checker, buffers good bytes
module usrt_rx_ctrl
    import usrt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic           i_Pclk,
    input  logic           i_Rst,
    input  logic           i_Enable,
    input  logic           i_Rx,
    input  logic [1:0]     i_Parity,
    usrt_rx_ctrl_if.master bus,
    output logic           o_ParErr,
    output logic           o_FrmErr,
    output logic           o_Overrun,
    input  logic           i_ClrErr
);

    rx_state_t state, state_nx;
    logic [9:0] sr;
    logic [3:0] cnt;
    logic [1:0] mode;
    logic last, start, done, c1, push, pop, full, empty;

    // last bit after the start bit is the stop bit: 9 bits without parity, 10 with
    assign last = cnt == (par_none(mode) ? 4'd8 : 4'd9);

    // next-state: start on a low line while enabled, leave SHIFT on stop bit or disable
    always_comb begin
        start    = state == IDLE && i_Enable && !i_Rx;
        done     = state == SHIFT && i_Enable && last;
        state_nx = start ? SHIFT : (state == SHIFT && (!i_Enable || last)) ? IDLE : state;
    end

    // state register
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_nx;
    end

    // shift register holds start bit plus bits received so far; mode frozen at start bit
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            sr   <= '0;
            cnt  <= '0;
            mode <= PAR_NONE;
        end else if (start) begin
            sr   <= '0;
            cnt  <= '0;
            mode <= i_Parity;
        end else if (state == SHIFT) begin
            sr  <= {sr[8:0], i_Rx};
            cnt <= cnt + 4'd1;
        end
    end

    // frame handoff; no-parity frames get a 0 in the parity slot so data stays at [9:2]
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            bus.o_Frame     <= '0;
            bus.o_FrameStb  <= 1'b0;
            bus.o_ChkParity <= PAR_NONE;
            c1              <= 1'b0;
        end else begin
            bus.o_FrameStb <= done;
            c1             <= bus.o_FrameStb;
            if (done) begin
                bus.o_Frame     <= par_none(mode) ? {sr[8:0], 1'b0, i_Rx} : {sr, i_Rx};
                bus.o_ChkParity <= mode;
            end
        end
    end

    assign push        = c1 & bus.o_Frame[STOP_BIT] & bus.i_ParityOK;
    assign pop         = bus.o_Valid & bus.i_Ready;
    assign bus.o_Valid = ~empty;

    // sticky flags: a set event in the clearing cycle keeps the flag high
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            o_ParErr  <= 1'b0;
            o_FrmErr  <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            o_FrmErr  <= (c1 & ~bus.o_Frame[STOP_BIT]) | (o_FrmErr & ~i_ClrErr);
            o_ParErr  <= (c1 & bus.o_Frame[STOP_BIT] & ~bus.i_ParityOK) | (o_ParErr & ~i_ClrErr);
            o_Overrun <= (push & full & ~pop) | (o_Overrun & ~i_ClrErr);
        end
    end

    usrt_rx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .i_Pclk (i_Pclk),
        .i_Rst  (i_Rst),
        .i_Push (push),
        .i_Pop  (pop),
        .i_Din  (bus.o_Frame[DATA_MSB:DATA_LSB]),
        .o_Dout (bus.o_Data),
        .o_Full (full),
        .o_Empty(empty)
    );

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb_usrt_rx_ctrl: vector table plus corner sequences, with a byte scoreboard on the output FIFO
module tb_usrt_rx_ctrl;
    import usrt_pkg::*;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1, clr = 1'b0;
    logic [1:0] par = PAR_EVEN;
    logic perr, ferr, ovr;
    int errors = 0, checks = 0, stbs = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] d;
        logic       p;
        logic       stop;
    } vec_t;
    vec_t tbl[8];

    usrt_rx_ctrl_if v();

    usrt_rx_ctrl #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .i_Pclk   (clk),
        .i_Rst    (rst),
        .i_Enable (en),
        .i_Rx     (rx),
        .i_Parity (par),
        .bus      (v),
        .o_ParErr (perr),
        .o_FrmErr (ferr),
        .o_Overrun(ovr),
        .i_ClrErr (clr)
    );

    always #5 clk = ~clk;

    function automatic logic par_ok(input logic [10:0] f, input logic [1:0] m);
        if (m == PAR_EVEN) return (^f[9:1]) == 1'b0;
        if (m == PAR_ODD)  return (^f[9:1]) == 1'b1;
        return 1'b1;
    endfunction

    function automatic logic good_p(input logic [1:0] m, input logic [7:0] d);
        return (m == PAR_ODD) ? ~^d : ^d;
    endfunction

    function automatic logic [10:0] exp_frame(input logic [1:0] m, input logic [7:0] d,
                                              input logic p, input logic stop);
        return {1'b0, d, (m == PAR_EVEN || m == PAR_ODD) ? p : 1'b0, stop};
    endfunction

    // stand-in for the parity checker beside this block: registered verdict
    always @(posedge clk or posedge rst) begin
        if (rst) v.i_ParityOK <= 1'b0;
        else     v.i_ParityOK <= par_ok(v.o_Frame, v.o_ChkParity);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v.o_FrameStb) stbs++;
        if (!rst && v.o_Valid && v.i_Ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected no data", v.o_Data);
            end else check("fifo_data", v.o_Data, q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d, input logic p, input logic stop);
        par = m;
        rx  = 1'b0;
        tick();
        par = ~m;
        for (int i = 7; i >= 0; i--) begin
            rx = d[i];
            tick();
        end
        if (m == PAR_EVEN || m == PAR_ODD) begin
            rx = p;
            tick();
        end
        rx = stop;
        tick();
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [1:0] m, input logic [7:0] d);
        q.push_back(d);
        send(m, d, good_p(m, d), 1'b1);
    endtask

    task automatic drain;
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{PAR_ODD,  8'hA5, 1'b0, 1'b1};
        tbl[1] = '{PAR_EVEN, 8'hA5, 1'b0, 1'b1};
        tbl[2] = '{PAR_NONE, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{PAR_NONE, 8'h81, 1'b0, 1'b1};
        tbl[4] = '{PAR_EVEN, 8'hFF, 1'b1, 1'b1};
        tbl[5] = '{PAR_ODD,  8'h00, 1'b1, 1'b1};
        tbl[6] = '{2'b11,    8'h7E, 1'b0, 1'b1};
        tbl[7] = '{PAR_EVEN, 8'h12, 1'b0, 1'b0};
        v.i_Ready = 1'b1;

        #12;
        check("reset_state", {v.o_Frame, v.o_FrameStb, v.o_ChkParity, v.o_Data, v.o_Valid, perr, ferr, ovr}, 0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        q.push_back(8'hA5);
        send(PAR_EVEN, 8'hA5, 1'b0, 1'b1);
        check("lat_stb", v.o_FrameStb, 1);
        check("lat_frame", v.o_Frame, 11'b0_10100101_0_1);
        check("lat_chkpar", v.o_ChkParity, PAR_EVEN);
        tick();
        check("lat_c1", {v.o_FrameStb, v.o_Valid}, 0);
        tick();
        check("lat_valid", v.o_Valid, 1);
        check("lat_flags", {perr, ferr, ovr}, 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            logic [10:0] f;
            logic ep, ef;
            f  = exp_frame(tbl[k].mode, tbl[k].d, tbl[k].p, tbl[k].stop);
            ef = !tbl[k].stop;
            ep = tbl[k].stop && !par_ok(f, tbl[k].mode);
            if (!ef && !ep) q.push_back(tbl[k].d);
            send(tbl[k].mode, tbl[k].d, tbl[k].p, tbl[k].stop);
            repeat (3) tick();
            check($sformatf("vec%0d_flags", k), {perr, ferr, ovr}, {ep, ef, 1'b0});
            clr = 1'b1;
            tick();
            clr = 1'b0;
            check($sformatf("vec%0d_clr", k), {perr, ferr, ovr}, 0);
        end

        send(PAR_NONE, 8'h3C, 1'b0, 1'b0);
        send_good(PAR_NONE, 8'h81);
        repeat (3) tick();
        check("b2b_flags", {perr, ferr}, 2'b01);
        send(PAR_EVEN, 8'hFF, 1'b1, 1'b1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("set_beats_clr", {perr, ferr}, 2'b10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_after", perr, 0);

        v.i_Ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) q.push_back(8'(k));
            send(PAR_EVEN, 8'(k), good_p(PAR_EVEN, 8'(k)), 1'b1);
        end
        repeat (3) tick();
        check("ovr_flag", {ovr, v.o_Valid}, 2'b11);
        check("ovr_head", v.o_Data, 8'h01);
        v.i_Ready = 1'b1;
        drain();
        tick();
        check("ovr_empty", v.o_Valid, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        v.i_Ready = 1'b0;
        send(PAR_EVEN, 8'h42, good_p(PAR_EVEN, 8'h42), 1'b1);
        send(PAR_EVEN, 8'h10, good_p(PAR_EVEN, 8'h10), 1'b0);
        repeat (3) tick();
        check("pre_rst", {v.o_Valid, ferr}, 2'b11);
        par = PAR_EVEN;
        rx  = 1'b0;
        tick();
        for (int i = 7; i > 2; i--) begin
            rx = i[0];
            tick();
        end
        #2 rst = 1'b1;
        #1;
        check("midframe_rst", {v.o_Frame, v.o_FrameStb, v.o_ChkParity, v.o_Data, v.o_Valid, perr, ferr, ovr}, 0);
        #1 rst = 1'b0;
        rx = 1'b1;
        v.i_Ready = 1'b1;
        tick();
        send_good(PAR_EVEN, 8'h55);
        repeat (4) tick();
        drain();

        begin
            int s0;
            logic [7:0] d;
            s0 = stbs;
            d  = 8'h96;
            par = PAR_EVEN;
            rx  = 1'b0;
            tick();
            for (int i = 7; i > 3; i--) begin
                rx = d[i];
                tick();
            end
            en = 1'b0;
            rx = d[3];
            tick();
            en = 1'b1;
            rx = 1'b1;
            repeat (12) tick();
            check("abort_nostb", stbs - s0, 0);
            check("abort_quiet", {v.o_Valid, perr, ferr, ovr}, 0);
        end
        send_good(PAR_ODD, 8'h3A);
        repeat (4) tick();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usrt_rx_ctrl.md
Name: usrt_rx_ctrl

Overview:
Receive-side sequencer for the USRT. It samples the synchronous serial line once per bit clock and assembles an 11-bit frame. It hands the frame to the existing parity checker and waits for the checker's registered verdict. Good bytes are pushed into a small output FIFO with a valid/ready handshake. It also keeps sticky parity, framing and overrun error flags for the host side.

Parameters:
FIFO_DEPTH, 4, output byte buffer entries; power of two, minimum 2
FIFO_AW, 2, log2(FIFO_DEPTH); FIFO pointer width

Ports:
i_Pclk  in  1  bit clock; every rising edge samples one serial bit
i_Rst  in  1  reset, asynchronous, active-high
i_Enable  in  1  receiver enable; low aborts any frame in progress
i_Rx  in  1  serial data line, idle high
i_Parity  in  2  01 even, 10 odd, 00/11 none; latched at start bit
o_Frame  out  11  frame to parity checker: [10] start, [9:2] data, [1] parity, [0] stop
o_FrameStb  out  1  one-cycle pulse when o_Frame holds a new frame
o_ChkParity  out  2  parity mode latched for the frame on o_Frame
i_ParityOK  in  1  checker verdict, valid 1 cycle after o_FrameStb
o_Data  out  8  head of output FIFO
o_Valid  out  1  FIFO not empty
i_Ready  in  1  consumer accepts o_Data when o_Valid and i_Ready are both high
o_ParErr  out  1  sticky parity error
o_FrmErr  out  1  sticky framing error (stop bit 0)
o_Overrun  out  1  sticky: a good byte was dropped because the FIFO was full
i_ClrErr  in  1  clears all three sticky flags

Behaviour:
- Reset (async, any time, including mid-frame):
  - o_Frame=0, o_FrameStb=0, o_ChkParity=0, o_Data=0, o_Valid=0, all flags=0.
  - FSM goes to IDLE; bit counter=0; FIFO pointers and count=0.
- Receive FSM:
  - IDLE: when i_Enable=1 and i_Rx=0, load the start bit, latch i_Parity, set the bit counter and go to SHIFT.
  - SHIFT: shift left, so frame <= {frame[9:0], i_Rx}.
  - Frame length is 11 bits with parity and 10 bits with none. In none mode, a 0 is inserted at bit [1] before the stop bit so the data always sits at [9:2].
  - On the edge that samples the stop bit: load o_Frame, pulse o_FrameStb, drive o_ChkParity, return to IDLE.
  - A start bit is accepted on the very next cycle after a stop bit.
  - Data is received MSB first: data[7] lands in frame[9].
  - i_Enable low in SHIFT: drop to IDLE next edge; no strobe, no flags.
- Check pipeline (independent of the FSM, so it overlaps the next frame):
  - C0 = cycle of o_FrameStb. The checker samples o_Frame at the end of C0.
  - C1: evaluate i_ParityOK together with the stop bit (o_Frame[0], held unchanged since C0).
  - C1 outcomes:
    - stop=0: set o_FrmErr, discard the byte.
    - else parity not OK: set o_ParErr, discard the byte.
    - else: push o_Frame[9:2].
  - o_Frame must stay stable through C1; minimum frame spacing of 10 cycles guarantees this.
- FIFO:
  - Write at end of C1; o_Valid rises the next cycle. Pop when o_Valid & i_Ready.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push while full without a pop: byte dropped, o_Overrun set.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; count is FIFO_AW+1 bits.
- Latency: start bit sampled at edge E0 gives o_FrameStb in cycle E10+1 (parity mode), C1 in E10+2, and o_Valid high from E10+3.
- Flags:
  - i_ClrErr clears all sticky flags.
  - A set event in the same cycle as i_ClrErr wins: the flag stays 1.
- i_Parity changes mid-frame: no effect until the next start bit.

Decomposition:
- Package usrt_pkg:
  - Parity codes PAR_NONE=00, PAR_EVEN=01, PAR_ODD=10.
  - Frame index constants START_BIT=10, DATA_MSB=9, DATA_LSB=2, PAR_BIT=1, STOP_BIT=0.
  - FSM state enum {IDLE, SHIFT}.
- Sub-module usrt_rx_fifo: synchronous FIFO, parameterised depth, with push, pop, full, empty and dout.
- The parity checker is instantiated beside this block, not inside it.

Test Plan:
- Even parity, stream 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1), i_Ready=1 -> o_FrameStb in cycle 11, o_Data=0xA5 with o_Valid=1 in cycle 13, no flags.
- Odd parity, 0xA5 sent with parity bit 0 -> o_ParErr=1, o_Valid stays 0; then i_ClrErr pulse -> o_ParErr=0.
- No parity, 0x3C then stop=0 -> o_FrmErr=1, nothing pushed; a following back-to-back frame 0x81 with stop=1 -> o_Data=0x81.
- i_Ready=0, five consecutive good frames 0x01..0x05, depth 4 -> FIFO holds 01..04, o_Overrun=1; popping yields 01,02,03,04 in order.
- Reset asserted at bit 5 of a frame -> all outputs 0 immediately; the next full frame 0x55 is received correctly.
- i_Enable dropped at bit 4 -> no o_FrameStb and no flags; FSM accepts the next start bit once i_Enable=1.
